// File: rtl/vga_timing_gen.sv
// ---------------------------------------------------------------------------
// vga_timing_gen
//   VGA 640x480@60 Hz timing generator driven from the 50 MHz board clock.
//   A clock divider produces a one-clk pixel strobe (pix_en) and a 50% duty
//   pixel clock for the DAC; hcount/vcount advance once per pixel period and
//   sync/blank/frame outputs are registered from the next-count values so
//   they line up with the hcount/vcount shown in the same cycle.
//
// Optional feature (macro VGA_FRAME_CNT_EN):
//   When defined, an 8-bit frame counter port frame_cnt is added; it steps on
//   every frame_start and wraps 255->0. When undefined the port and its
//   register are absent and everything else is unchanged.
//
// Ports:
//   clk          in   system clock (50 MHz)
//   rst          in   asynchronous active-high reset
//   hcount[9:0]  out  pixel column, 0..H_TOTAL-1
//   vcount[9:0]  out  line, 0..V_TOTAL-1
//   pix_en       out  one-clk strobe per pixel period
//   vga_clk      out  pixel clock to DAC, 50% duty
//   hsync        out  horizontal sync, active low
//   vsync        out  vertical sync, active low
//   blank_n      out  high inside the active area
//   sync_n       out  composite sync to DAC, tied low
//   frame_start  out  one-clk pulse when (hcount,vcount) wraps to (0,0)
//   frame_cnt    out  frame counter (only with VGA_FRAME_CNT_EN)
//
// CLK_DIV must be even and >= 2; H_TOTAL and V_TOTAL must not exceed 1024.
// ---------------------------------------------------------------------------
module vga_timing_gen #(
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33,
  parameter int CLK_DIV  = 2
) (
  input  logic       clk,
  input  logic       rst,
  output logic [9:0] hcount,
  output logic [9:0] vcount,
  output logic       pix_en,
  output logic       vga_clk,
  output logic       hsync,
  output logic       vsync,
  output logic       blank_n,
  output logic       sync_n,
  output logic       frame_start
`ifdef VGA_FRAME_CNT_EN
  ,
  output logic [7:0] frame_cnt
`endif
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int DIV_W   = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;

  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
  localparam logic [DIV_W-1:0] DIV_HALF = DIV_W'(CLK_DIV / 2);

  localparam logic [9:0] H_LAST   = 10'(H_TOTAL - 1);
  localparam logic [9:0] V_LAST   = 10'(V_TOTAL - 1);
  localparam logic [9:0] H_ACT    = 10'(H_ACTIVE);
  localparam logic [9:0] V_ACT    = 10'(V_ACTIVE);
  localparam logic [9:0] HS_START = 10'(H_ACTIVE + H_FP);
  localparam logic [9:0] VS_START = 10'(V_ACTIVE + V_FP);

  // Sync end bounds are kept 11 bits wide so a sync pulse ending exactly at
  // 1024 still compares correctly against a 10-bit count.
  localparam logic [10:0] HS_END = 11'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [10:0] VS_END = 11'(V_ACTIVE + V_FP + V_SYNC);

  logic [DIV_W-1:0] div;
  logic [9:0]       h_next;
  logic [9:0]       v_next;
  logic             frame_wrap;

  // Next pixel position; only moves on a pixel strobe.
  always_comb begin
    h_next = hcount;
    v_next = vcount;
    if (pix_en) begin
      if (hcount == H_LAST) begin
        h_next = '0;
        if (vcount == V_LAST) begin
          v_next = '0;
        end else begin
          v_next = vcount + 10'd1;
        end
      end else begin
        h_next = hcount + 10'd1;
      end
    end
  end

  assign frame_wrap = pix_en && (hcount == H_LAST) && (vcount == V_LAST);

  // pix_en and vga_clk are registered from the current divider phase, so
  // both lag div by one clk; with this the first strobe after reset release
  // lands exactly CLK_DIV clks later and vga_clk rises together with pix_en.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      div         <= '0;
      pix_en      <= 1'b0;
      vga_clk     <= 1'b0;
      hcount      <= '0;
      vcount      <= '0;
      hsync       <= 1'b1;
      vsync       <= 1'b1;
      blank_n     <= 1'b1;
      frame_start <= 1'b0;
    end else begin
      div         <= (div == DIV_LAST) ? '0 : div + DIV_W'(1);
      pix_en      <= (div == DIV_LAST);
      vga_clk     <= (div >= DIV_HALF);
      hcount      <= h_next;
      vcount      <= v_next;
      hsync       <= !((h_next >= HS_START) && ({1'b0, h_next} < HS_END));
      vsync       <= !((v_next >= VS_START) && ({1'b0, v_next} < VS_END));
      blank_n     <= (h_next < H_ACT) && (v_next < V_ACT);
      frame_start <= frame_wrap;
    end
  end

`ifdef VGA_FRAME_CNT_EN
  // Steps on the same edge that raises frame_start, so the new frame number
  // is visible together with the pulse.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      frame_cnt <= '0;
    end else if (frame_wrap) begin
      frame_cnt <= frame_cnt + 8'd1;
    end
  end
`endif

  assign sync_n = 1'b0;

endmodule

// File: tb/tb_vga_timing_gen.sv
module tb_vga_timing_gen;

  logic clk;
  logic rst;

  logic [9:0] hc_f, vc_f, hc_s, vc_s;
  logic pe_f, vk_f, hs_f, vs_f, bl_f, sn_f, fs_f;
  logic pe_s, vk_s, hs_s, vs_s, bl_s, sn_s, fs_s;
  logic [7:0] fc_f, fc_s;

  int n_checks = 0;
  int n_fail   = 0;
  int t        = 0;   // clk edges since reset release

  vga_timing_gen dut_full (
    .clk(clk), .rst(rst), .hcount(hc_f), .vcount(vc_f), .pix_en(pe_f),
    .vga_clk(vk_f), .hsync(hs_f), .vsync(vs_f), .blank_n(bl_f),
    .sync_n(sn_f), .frame_start(fs_f)
`ifdef VGA_FRAME_CNT_EN
    , .frame_cnt(fc_f)
`endif
  );

  vga_timing_gen #(
    .H_ACTIVE(8), .H_FP(1), .H_SYNC(1), .H_BP(1),
    .V_ACTIVE(4), .V_FP(1), .V_SYNC(1), .V_BP(1), .CLK_DIV(2)
  ) dut_small (
    .clk(clk), .rst(rst), .hcount(hc_s), .vcount(vc_s), .pix_en(pe_s),
    .vga_clk(vk_s), .hsync(hs_s), .vsync(vs_s), .blank_n(bl_s),
    .sync_n(sn_s), .frame_start(fs_s)
`ifdef VGA_FRAME_CNT_EN
    , .frame_cnt(fc_s)
`endif
  );

`ifndef VGA_FRAME_CNT_EN
  assign fc_f = 8'd0;
  assign fc_s = 8'd0;
`endif

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int h; int v; int pix; int vclk; int hs; int vs; int bl; int fs; int fc;
  } exp_t;

  // Expected outputs after t edges of free running, from the timing rules:
  // n pixel advances have happened, position is n in raster order.
  function automatic exp_t model(input int tt, input int ha, input int hf,
                                 input int hsw, input int hb, input int va,
                                 input int vf, input int vsw, input int vb,
                                 input int cd);
    exp_t e;
    int ht, vt, n;
    ht = ha + hf + hsw + hb;
    vt = va + vf + vsw + vb;
    n  = (tt == 0) ? 0 : (tt - 1) / cd;
    e.h    = n % ht;
    e.v    = (n / ht) % vt;
    e.pix  = (tt > 0 && tt % cd == 0) ? 1 : 0;
    e.vclk = (tt > 0 && ((tt - 1) % cd) >= cd / 2) ? 1 : 0;
    e.hs   = (e.h >= ha + hf && e.h < ha + hf + hsw) ? 0 : 1;
    e.vs   = (e.v >= va + vf && e.v < va + vf + vsw) ? 0 : 1;
    e.bl   = (e.h < ha && e.v < va) ? 1 : 0;
    e.fs   = (tt > 0 && (tt - 1) % cd == 0 && n > 0 && n % (ht * vt) == 0) ? 1 : 0;
    e.fc   = (n / (ht * vt)) % 256;
    return e;
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0d, time %0t)", name, act, exp, t, $time);
    end
  endtask

  task automatic chk_dut(input string p, input exp_t e, input int h, input int v,
                         input int pe, input int vk, input int hs, input int vs,
                         input int bl, input int sn, input int fs, input int fc);
    chk({p, ".hcount"}, h, e.h);
    chk({p, ".vcount"}, v, e.v);
    chk({p, ".pix_en"}, pe, e.pix);
    chk({p, ".vga_clk"}, vk, e.vclk);
    chk({p, ".hsync"}, hs, e.hs);
    chk({p, ".vsync"}, vs, e.vs);
    chk({p, ".blank_n"}, bl, e.bl);
    chk({p, ".sync_n"}, sn, 0);
    chk({p, ".frame_start"}, fs, e.fs);
`ifdef VGA_FRAME_CNT_EN
    chk({p, ".frame_cnt"}, fc, e.fc);
`endif
  endtask

  // Per-cycle compare: advance the model on each edge, sample 1 time unit later.
  initial begin
    exp_t ef, es;
    forever begin
      @(posedge clk);
      if (rst) t = 0;
      else     t = t + 1;
      #1;
      ef = model(t, 640, 16, 96, 48, 480, 10, 2, 33, 2);
      es = model(t, 8, 1, 1, 1, 4, 1, 1, 1, 2);
      chk_dut("full", ef, hc_f, vc_f, pe_f, vk_f, hs_f, vs_f, bl_f, sn_f, fs_f, fc_f);
      chk_dut("small", es, hc_s, vc_s, pe_s, vk_s, hs_s, vs_s, bl_s, sn_s, fs_s, fc_s);

      // Hand-computed points that pin the model.
      if (t == 1)     chk("lit.first_pix_en_low", pe_f, 0);
      if (t == 2)     chk("lit.first_pix_en", pe_f, 1);
      if (t == 1279)  chk("lit.blank_n_639", bl_f, 1);
      if (t == 1281)  chk("lit.blank_n_640", bl_f, 0);
      if (t == 1311)  chk("lit.hsync_655", hs_f, 1);
      if (t == 1313)  chk("lit.hsync_656", hs_f, 0);
      if (t == 1503)  chk("lit.hsync_751", hs_f, 0);
      if (t == 1505)  chk("lit.hsync_752", hs_f, 1);
      if (t == 1599)  chk("lit.hcount_799", hc_f, 799);
      if (t == 1601) begin
        chk("lit.hcount_wrap", hc_f, 0);
        chk("lit.vcount_step", vc_f, 1);
        chk("lit.blank_n_line1", bl_f, 1);
      end
      if (t == 109)   chk("lit.small_vsync_v4", vs_s, 1);
      if (t == 111)   chk("lit.small_vsync_v5", vs_s, 0);
      if (t == 133)   chk("lit.small_vsync_v6", vs_s, 1);
      if (t == 153)   chk("lit.small_fs_before", fs_s, 0);
      if (t == 155)   chk("lit.small_frame_start", fs_s, 1);
      if (t == 156)   chk("lit.small_fs_width", fs_s, 0);
`ifdef VGA_FRAME_CNT_EN
      if (t == 155)   chk("lit.frame_cnt_1", fc_s, 1);
      if (t == 39423) chk("lit.frame_cnt_255", fc_s, 255);
      if (t == 39425) chk("lit.frame_cnt_wrap", fc_s, 0);
`endif
    end
  end

  initial begin
    int waited;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;

    // Free run: several lines of the full timing, many small frames.
    repeat (5000) @(negedge clk);

    // Reset mid-line at hcount=300.
    waited = 0;
    while (hc_f != 10'd300 && waited < 3000) begin
      @(negedge clk);
      waited++;
    end
    chk("wait_hcount_300", (hc_f == 10'd300) ? 1 : 0, 1);
    #2 rst = 1'b1;
    #1;
    chk("async.hcount", hc_f, 0);
    chk("async.vcount", vc_f, 0);
    chk("async.pix_en", pe_f, 0);
    chk("async.vga_clk", vk_f, 0);
    chk("async.hsync", hs_f, 1);
    chk("async.blank_n", bl_f, 1);
    chk("async.frame_start", fs_f, 0);
    chk("async.small_hcount", hc_s, 0);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (300) @(negedge clk);

    // Random reset pulses at random points, including mid-cycle assertion.
    for (int i = 0; i < 20; i++) begin
      repeat ($urandom_range(10, 400)) @(negedge clk);
      #($urandom_range(0, 3)) rst = 1'b1;
      repeat ($urandom_range(1, 4)) @(negedge clk);
      rst = 1'b0;
    end

    // Long uninterrupted run: covers 256+ small frames (frame_cnt wrap).
    repeat (41000) @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/vga_timing_gen.md
Name: vga_timing_gen

Overview:
- Generates VGA 640x480@60 Hz timing from the 50 MHz board clock.
- Provides the pixel-coordinate counters hcount/vcount consumed directly by the grid-cell position decoder and pixel colour mux.
- Also drives the off-chip DAC/connector sync, blank and pixel-clock pins.
- Sits at the head of the video pipeline; all downstream video logic is qualified by pix_en.

Parameters:
- H_ACTIVE, 640, visible pixels per line
- H_FP, 16, horizontal front porch (pixels)
- H_SYNC, 96, hsync pulse width (pixels)
- H_BP, 48, horizontal back porch (pixels)
- V_ACTIVE, 480, visible lines per frame
- V_FP, 10, vertical front porch (lines)
- V_SYNC, 2, vsync pulse width (lines)
- V_BP, 33, vertical back porch (lines)
- CLK_DIV, 2, clk cycles per pixel; must be even and >=2

Ports:
- clk  in  1  system clock, 50 MHz
- rst  in  1  asynchronous, active-high reset
- hcount  out  10  current pixel column, 0..H_TOTAL-1
- vcount  out  10  current line, 0..V_TOTAL-1
- pix_en  out  1  one-clk strobe, once per pixel period
- vga_clk  out  1  pixel clock to DAC, 50% duty
- hsync  out  1  horizontal sync, active low
- vsync  out  1  vertical sync, active low
- blank_n  out  1  high when (hcount,vcount) is in the active area
- sync_n  out  1  composite sync to DAC, tied 0
- frame_start  out  1  one-clk pulse at the start of each frame
- frame_cnt  out  8  frame counter; present only with the optional feature

Behaviour:
- Derived constants: H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP (800); V_TOTAL = V_ACTIVE+V_FP+V_SYNC+V_BP (525).
- Divider:
  - div counts 0..CLK_DIV-1 and wraps.
  - pix_en is registered and high in the cycle when div==CLK_DIV-1.
  - vga_clk is registered, low while div<CLK_DIV/2, high otherwise.
- Counters advance only on clk edges where pix_en=1.
  - hcount increments; at H_TOTAL-1 it wraps to 0.
  - On that same edge vcount increments; at V_TOTAL-1 it wraps to 0.
- Sync, blank and frame outputs are registered from the next-count values, so they always correspond to the hcount/vcount presented in the same cycle. There is zero relative latency.
  - hsync=0 iff H_ACTIVE+H_FP <= hcount < H_ACTIVE+H_FP+H_SYNC, i.e. 656..751.
  - vsync=0 iff V_ACTIVE+V_FP <= vcount < V_ACTIVE+V_FP+V_SYNC, i.e. 490..491.
  - blank_n=1 iff hcount<H_ACTIVE and vcount<V_ACTIVE.
  - frame_start=1 for exactly one clk, on the cycle in which (hcount,vcount) first become (0,0) after a wrap. It does not fire at reset release.
- Reset (async assert; release synchronous to clk):
  - div=0; hcount=0; vcount=0.
  - pix_en=0, vga_clk=0, hsync=1, vsync=1, blank_n=1, frame_start=0, frame_cnt=0.
  - Reset mid-line or mid-frame aborts the frame immediately. The first pix_en comes CLK_DIV cycles after release.
- Counter widths are 10 bits. Parameters must keep H_TOTAL and V_TOTAL <= 1024; no saturation logic is provided.
- No input handshake. Downstream stages sample hcount/vcount only when pix_en=1.

Optional Feature:
- Macro: VGA_FRAME_CNT_EN.
- Defined:
  - frame_cnt port exists.
  - It increments by 1 on every frame_start and wraps 255->0.
  - Used for blink/animation timing.
- Undefined: the frame_cnt port and its register are absent. All other behaviour is identical.

Test Plan:
- Reset then run 2000 clk -> pix_en every 2nd clk; hcount goes 0..799 then 0; vcount steps 0->1 at clk ~1600; vga_clk is a 25 MHz square wave.
- Observe one line -> hsync low for exactly 96 pixels (hcount 656..751); blank_n falls at hcount 640 and rises at hcount 0.
- Run one full frame (840000 clk) -> vsync low for vcount 490..491 (1600 clk); blank_n=0 for all vcount>=480; frame_start pulses once, one clk wide, at (0,0).
- Assert rst at hcount=300, vcount=200 for 3 clk -> all outputs go to reset values immediately; after release, counting restarts from (0,0) with the first pix_en after 2 clk; no frame_start.
- With VGA_FRAME_CNT_EN and shrunk parameters (H_ACTIVE=8, porches/syncs=1, V_ACTIVE=4) -> frame_cnt increments once per frame and wraps 255->0 after 256 frames.
- Without VGA_FRAME_CNT_EN -> the build has no frame_cnt port; hcount/vcount/sync waveforms match the defined build cycle-for-cycle.
